// File: rtl/db_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single DataBus slave.
// One transaction in flight at a time; a watchdog aborts transactions the slave never completes.
module db_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              res,
  input  logic [1:0]        m0_accessType,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dataOut,
  output logic [DATA_W-1:0] m0_dataIn,
  output logic              m0_ready,
  output logic              m0_err,
  input  logic [1:0]        m1_accessType,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dataOut,
  output logic [DATA_W-1:0] m1_dataIn,
  output logic              m1_ready,
  output logic              m1_err,
  output logic [1:0]        s_accessType,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_dataOut,
  input  logic [DATA_W-1:0] s_dataIn,
  input  logic              s_ready,
  output logic              busy,
  output logic              grant
);

  // DataBus access encoding: NONE=00, R=01, W=10, X=11.
  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_W    = 2'b10;

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_next;
  logic              last_served;
  logic [WD_W-1:0]   wd;
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic              req0, req1, sel, done, expire, rd_done;

  assign busy = (state == BUSY);

  // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    state_next = state;
    sel        = 1'b0;
    done       = 1'b0;
    expire     = 1'b0;
    req0       = (m0_accessType != ACC_NONE);
    req1       = (m1_accessType != ACC_NONE);
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next = BUSY;
          // With both pending, serve the master that did not go last.
          sel = (req0 && req1) ? ~last_served : req1;
        end
      end
      BUSY: begin
        if (s_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (TIMEOUT != 0 && wd == WD_LAST) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
    endcase

    // Writes never touch the read-data path.
    rd_done   = done && (s_accessType != ACC_W);
    m0_ready  = done && !grant;
    m1_ready  = done && grant;
    m0_err    = expire && !grant;
    m1_err    = expire && grant;
    m0_dataIn = (rd_done && !grant) ? s_dataIn : rd0_q;
    m1_dataIn = (rd_done && grant) ? s_dataIn : rd1_q;
  end

  // NOTE: sequential state is always updated with non-blocking assignments so all registers
  // see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      s_accessType <= ACC_NONE;
      s_addr       <= '0;
      s_dataOut    <= '0;
      grant        <= 1'b0;
      last_served  <= 1'b1;
      wd           <= '0;
      rd0_q        <= '0;
      rd1_q        <= '0;
    end else begin
      if (state == IDLE && state_next == BUSY) begin
        grant        <= sel;
        s_accessType <= sel ? m1_accessType : m0_accessType;
        s_addr       <= sel ? m1_addr       : m0_addr;
        s_dataOut    <= sel ? m1_dataOut    : m0_dataOut;
        wd           <= '0;
      end

      if (done || expire) begin
        s_accessType <= ACC_NONE;
        last_served  <= grant;
      end else if (state == BUSY && TIMEOUT != 0) begin
        wd <= wd + 1'b1;
      end

      if (rd_done) begin
        if (grant) rd1_q <= s_dataIn;
        else       rd0_q <= s_dataIn;
      end
    end
  end

endmodule

// File: tb/tb_db_bus_arbiter.sv
// Randomized bench for db_bus_arbiter: transaction-level arbitration model plus a
// scoreboard that checks every ready/err pulse each master receives.
module tb_db_bus_arbiter;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] RD   = 2'b01;
  localparam logic [1:0] WR   = 2'b10;
  localparam logic [1:0] XC   = 2'b11;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [1:0]  m0_accessType, m1_accessType, s_accessType;
  logic [31:0] m0_addr, m0_dataOut, m0_dataIn;
  logic [31:0] m1_addr, m1_dataOut, m1_dataIn;
  logic [31:0] s_addr, s_dataOut, s_dataIn;
  logic        m0_ready, m0_err, m1_ready, m1_err, s_ready, busy, grant;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  db_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .res(res),
    .m0_accessType(m0_accessType), .m0_addr(m0_addr), .m0_dataOut(m0_dataOut),
    .m0_dataIn(m0_dataIn), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_accessType(m1_accessType), .m1_addr(m1_addr), .m1_dataOut(m1_dataOut),
    .m1_dataIn(m1_dataIn), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_accessType(s_accessType), .s_addr(s_addr), .s_dataOut(s_dataOut),
    .s_dataIn(s_dataIn), .s_ready(s_ready),
    .busy(busy), .grant(grant)
  );

  typedef struct {
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: outstanding request per master, who went last, earliest free grant edge.
  bit          pend[2];
  bit          taken[2];
  int          req_edge[2];
  logic [1:0]  req_t[2];
  logic [31:0] req_a[2];
  logic [31:0] req_d[2];
  logic [31:0] last_rd[2];
  bit          last_srv = 1'b1;
  int          free_edge = 0;
  bit          chk_en = 1'b0;
  bit          slave_on = 1'b0;
  bit          allow_drop = 1'b0;
  int          force_d = -1;
  logic [31:0] force_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int m, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_accessType = t; m0_addr = a; m0_dataOut = d;
    end else begin
      m1_accessType = t; m1_addr = a; m1_dataOut = d;
    end
  endtask

  // Called at posedge+1; holds the request until ready/err, optionally dropping it once granted.
  task automatic issue(input int m, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    bit dropped = 1'b0;
    req_t[m] = t; req_a[m] = a; req_d[m] = d; req_edge[m] = cyc + 1; pend[m] = 1'b1;
    drive(m, t, a, d);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (m == 0 ? (m0_ready || m0_err) : (m1_ready || m1_err)) got = 1'b1;
      else if (allow_drop && taken[m] && !dropped && $urandom_range(0, 3) == 0) begin
        dropped = 1'b1;
        drive(m, NONE, $urandom, $urandom);
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL m%0d_completion: got none expected ready/err within 200 cycles", m);
    end
    @(posedge clk); #1;
    pend[m] = 1'b0; taken[m] = 1'b0;
    drive(m, NONE, '0, '0);
  endtask

  task automatic run_master(input int m, input int n);
    logic [1:0] t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      t = 2'($urandom_range(1, 3));
      issue(m, t, $urandom, $urandom);
    end
  endtask

  // Slave: checks the forwarded request against the arbitration rules, then answers.
  task automatic serve();
    int g, m, first, d, r;
    bit c0, c1;
    logic [31:0] data;
    exp_t e;
    g  = cyc;
    c0 = pend[0] && req_edge[0] <= g;
    c1 = pend[1] && req_edge[1] <= g;
    if (!c0 && !c1) begin
      total++; bad++;
      $display("FAIL grant_without_request: got s_accessType=%0h expected no transaction", s_accessType);
      return;
    end
    m = (c0 && c1) ? (last_srv ? 0 : 1) : (c1 ? 1 : 0);
    if (c0 && c1) first = (req_edge[0] < req_edge[1]) ? req_edge[0] : req_edge[1];
    else          first = req_edge[m];
    check("grant_edge", g, (free_edge > first) ? free_edge : first);
    check("grant", grant, m);
    check("s_accessType", s_accessType, req_t[m]);
    check("s_addr", s_addr, req_a[m]);
    check("s_dataOut", s_dataOut, req_d[m]);
    check("busy_set", busy, 1);
    taken[m] = 1'b1;
    if (force_d >= 0) begin
      d = force_d; data = force_data; force_d = -1;
    end else begin
      r = $urandom_range(0, 9);
      d = (r < 7) ? (r % 4) : 9;
      data = $urandom;
    end
    if (d < TO) begin
      e.err  = 1'b0;
      e.data = (req_t[m] != WR) ? data : last_rd[m];
      if (req_t[m] != WR) last_rd[m] = data;
      if (m == 0) q0.push_back(e); else q1.push_back(e);
      repeat (d) begin @(posedge clk); #1; end
      check("s_addr_hold", s_addr, req_a[m]);
      check("s_accessType_hold", s_accessType, req_t[m]);
      s_ready = 1'b1; s_dataIn = data;
      @(posedge clk); #1;
      s_ready = 1'b0; s_dataIn = $urandom;
    end else begin
      e.err  = 1'b1;
      e.data = last_rd[m];
      if (m == 0) q0.push_back(e); else q1.push_back(e);
      repeat (TO) begin @(posedge clk); #1; end
      check("busy_after_timeout", busy, 0);
      check("s_accessType_after_timeout", s_accessType, NONE);
    end
    last_srv  = (m == 1);
    free_edge = cyc + 1;
  endtask

  task automatic mon(input int m, input logic r, input logic er, input logic [31:0] d);
    exp_t x;
    if (r || er) begin
      if ((m == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        total++; bad++;
        $display("FAIL m%0d_unexpected_pulse: got ready=%0b err=%0b expected no pulse", m, r, er);
      end else begin
        x = (m == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("m%0d_err", m), er, x.err);
        check($sformatf("m%0d_ready", m), r, !x.err);
        check($sformatf("m%0d_dataIn", m), d, x.data);
      end
    end
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL global_timeout: got cycle %0d expected finish earlier", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    s_ready = 1'b0; s_dataIn = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; taken[i] = 1'b0; req_edge[i] = 0; last_rd[i] = '0;
      req_t[i] = NONE; req_a[i] = '0; req_d[i] = '0;
    end

    fork
      forever begin
        @(posedge clk); #1;
        if (slave_on && s_accessType != NONE) serve();
      end
      forever begin
        @(negedge clk);
        if (chk_en) begin
          mon(0, m0_ready, m0_err, m0_dataIn);
          mon(1, m1_ready, m1_err, m1_dataIn);
        end
      end
    join_none

    // Reset held while both masters request.
    drive(0, RD, 32'h40, 32'h0);
    drive(1, WR, 32'h4c, 32'h9);
    repeat (2) begin
      @(negedge clk);
      check("rst_s_accessType", s_accessType, NONE);
      check("rst_busy", busy, 0);
      check("rst_m0_ready", m0_ready, 0);
      check("rst_m1_ready", m1_ready, 0);
      check("rst_grant", grant, 0);
      check("rst_m0_dataIn", m0_dataIn, 0);
      check("rst_m1_dataIn", m1_dataIn, 0);
    end
    @(posedge clk); #1;
    res = 1'b0;
    drive(0, NONE, '0, '0);
    drive(1, NONE, '0, '0);
    chk_en = 1'b1; slave_on = 1'b1;
    @(posedge clk); #1;

    // Contention right after reset: m0 first, then m1.
    fork
      issue(0, XC, 32'h0, 32'h0);
      issue(1, WR, 32'h4c, 32'h9);
    join
    check("m1_dataIn_after_write", m1_dataIn, last_rd[1]);

    // Single read answered with 0x4.
    force_d = 2; force_data = 32'h4;
    issue(0, RD, 32'h40, 32'h0);
    check("m0_dataIn_held", m0_dataIn, 32'h4);

    // Random traffic from both masters.
    allow_drop = 1'b1;
    fork
      run_master(0, 40);
      run_master(1, 40);
    join
    repeat (8) begin @(posedge clk); #1; end
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    slave_on = 1'b0; chk_en = 1'b0; allow_drop = 1'b0;

    // Reset in the middle of a transaction: no pulse, back to idle.
    drive(0, RD, 32'h80, 32'h0);
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    check("mid_s_addr", s_addr, 32'h80);
    res = 1'b1;
    @(negedge clk);
    check("mid_m0_ready", m0_ready, 0);
    check("mid_m0_err", m0_err, 0);
    @(posedge clk); #1;
    res = 1'b0;
    drive(0, NONE, '0, '0);
    check("midrst_busy", busy, 0);
    check("midrst_s_accessType", s_accessType, NONE);
    check("midrst_m0_dataIn", m0_dataIn, 0);
    check("midrst_grant", grant, 0);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_m0_ready", m0_ready, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
